// File: rtl/agc_alu_pkg.sv
// Shared types and constants for the AGC-style one's-complement ALU sequencer.
package agc_alu_pkg;

    localparam int NUM_BIT_DEFAULT = 15;

    // Shift-add iterations for the default width: one per magnitude bit.
    localparam int MUL_ITER = NUM_BIT_DEFAULT - 1;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_MUL  = 2'd2,
        OP_RSVD = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_t;

    function automatic int cnt_width(input int iter);
        return (iter > 1) ? $clog2(iter) : 1;
    endfunction

endpackage

// File: rtl/ones_comp_add_sub.sv
// Combinational one's-complement adder/subtractor with end-around carry.
module ones_comp_add_sub #(
    parameter int NUM_BIT = 15
) (
    input  logic [NUM_BIT-1:0] a,
    input  logic [NUM_BIT-1:0] b,
    input  logic               sub,
    output logic [NUM_BIT-1:0] sum
);

    logic [NUM_BIT-1:0] b_eff;
    logic [NUM_BIT:0]   raw;

    // Subtraction is addition of the bitwise complement in one's complement.
    generate
        for (genvar gi = 0; gi < NUM_BIT; gi++) begin : g_inv
            assign b_eff[gi] = b[gi] ^ sub;
        end
    endgenerate

    assign raw = {1'b0, a} + {1'b0, b_eff};
    // A carry-out never ripples again: with a carry the low word is at most all-ones minus one.
    assign sum = raw[NUM_BIT-1:0] + {{(NUM_BIT-1){1'b0}}, raw[NUM_BIT]};

endmodule

// File: rtl/agc_alu_seq.sv
// One's-complement ALU: single-cycle ADD/SUB, sequential shift-add MUL, valid/ready handshakes.
module agc_alu_seq
    import agc_alu_pkg::*;
#(
    parameter int NUM_BIT = NUM_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           op,
    input  logic [NUM_BIT-1:0]   x,
    input  logic [NUM_BIT-1:0]   y,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [2*NUM_BIT-1:0] result,
    output logic                 busy
);

    localparam int MAG_W = NUM_BIT - 1;
    localparam int ITER  = NUM_BIT - 1;
    localparam int CNT_W = cnt_width(ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    alu_state_t           state_reg;
    logic [NUM_BIT-1:0]   acc_reg;
    logic [MAG_W-1:0]     mq_reg;
    logic [MAG_W-1:0]     x_mag_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic                 sign_reg;
    logic [2*NUM_BIT-1:0] result_reg;
    logic                 resp_valid_reg;
    logic                 ready_reg;
    logic                 busy_reg;

    alu_op_t              op_t;
    logic                 accept;
    logic [NUM_BIT-1:0]   addsub_sum;
    logic [MAG_W-1:0]     x_mag;
    logic [MAG_W-1:0]     y_mag;
    logic [NUM_BIT-1:0]   acc_sum;
    logic [2*NUM_BIT-1:0] mag;

    assign op_t   = alu_op_t'(op);
    assign accept = req_valid && req_ready;

    ones_comp_add_sub #(.NUM_BIT(NUM_BIT)) u_add_sub (
        .a   (x),
        .b   (y),
        .sub (op_t == OP_SUB),
        .sum (addsub_sum)
    );

    assign x_mag   = x[NUM_BIT-1] ? ~x[MAG_W-1:0] : x[MAG_W-1:0];
    assign y_mag   = y[NUM_BIT-1] ? ~y[MAG_W-1:0] : y[MAG_W-1:0];
    assign acc_sum = acc_reg + (mq_reg[0] ? {1'b0, x_mag_reg} : {NUM_BIT{1'b0}});
    assign mag     = {2'b00, acc_reg[MAG_W-1:0], mq_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            acc_reg        <= '0;
            mq_reg         <= '0;
            x_mag_reg      <= '0;
            cnt_reg        <= '0;
            sign_reg       <= 1'b0;
            result_reg     <= '0;
            resp_valid_reg <= 1'b0;
            ready_reg      <= 1'b0;
            busy_reg       <= 1'b0;
        end else if (clear) begin
            state_reg      <= ST_IDLE;
            acc_reg        <= '0;
            mq_reg         <= '0;
            cnt_reg        <= '0;
            sign_reg       <= 1'b0;
            result_reg     <= '0;
            resp_valid_reg <= 1'b0;
            ready_reg      <= 1'b1;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    ready_reg <= 1'b1;
                    if (accept) begin
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                        case (op_t)
                            OP_MUL: begin
                                sign_reg  <= x[NUM_BIT-1] ^ y[NUM_BIT-1];
                                acc_reg   <= '0;
                                mq_reg    <= y_mag;
                                x_mag_reg <= x_mag;
                                cnt_reg   <= '0;
                                state_reg <= ST_MUL;
                            end
                            OP_RSVD: begin
                                result_reg     <= '0;
                                resp_valid_reg <= 1'b1;
                                state_reg      <= ST_DONE;
                            end
                            default: begin
                                result_reg     <= {{NUM_BIT{addsub_sum[NUM_BIT-1]}}, addsub_sum};
                                resp_valid_reg <= 1'b1;
                                state_reg      <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_MUL: begin
                    // Add-then-shift: the sum's LSB drops into the top of the multiplier register.
                    acc_reg <= {1'b0, acc_sum[NUM_BIT-1:1]};
                    mq_reg  <= {acc_sum[0], mq_reg[MAG_W-1:1]};
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_FIX;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    // Zero products are always reported as +0, never -0.
                    if (mag == '0)
                        result_reg <= '0;
                    else
                        result_reg <= sign_reg ? ~mag : mag;
                    resp_valid_reg <= 1'b1;
                    state_reg      <= ST_DONE;
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        ready_reg      <= 1'b1;
                        busy_reg       <= 1'b0;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // The synchronous abort also blocks acceptance in the cycle it is raised.
    assign req_ready  = ready_reg && !clear;
    assign busy       = busy_reg;
    assign resp_valid = resp_valid_reg;
    assign result     = result_reg;

endmodule

// File: tb/tb_agc_alu_seq.sv
// Scoreboard bench for agc_alu_seq: directed vectors, queue of expected responses, decoupled monitor.
module tb_agc_alu_seq;

    localparam int NB = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    op;
    logic [NB-1:0] x;
    logic [NB-1:0] y;
    logic          resp_valid;
    logic          resp_ready;
    logic [2*NB-1:0] result;
    logic          busy;

    agc_alu_seq #(.NUM_BIT(NB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op         (op),
        .x          (x),
        .y          (y),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result     (result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*NB-1:0] res;
        int              due_edge;
        string           name;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   in_resp = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: the first cycle of each resp_valid pulse is matched against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!resp_valid) begin
                in_resp = 1'b0;
            end else if (!in_resp) begin
                in_resp = 1'b1;
                if (sb.size() == 0) begin
                    check("unexpected_resp", 64'(result), 64'hDEAD);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_result"}, 64'(result), 64'(e.res));
                    check({e.name, "_latency"}, 64'(cyc), 64'(e.due_edge));
                    $display("resp %s result=%h edge=%0d", e.name, result, cyc);
                end
            end
        end
    end

    // Present a request and wait for acceptance; returns the accept edge number.
    task automatic issue(input logic [1:0] o, input logic [NB-1:0] a, input logic [NB-1:0] b,
                         input string name, output int acc_edge);
        int i;
        for (i = 0; i < 30; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        acc_edge = -1;
        if (i == 30) begin
            check({name, "_ready_timeout"}, 64'(req_ready), 64'd1);
            return;
        end
        req_valid = 1'b1;
        op = o;
        x = a;
        y = b;
        @(posedge clk);
        #1;
        acc_edge = cyc;
        req_valid = 1'b0;
        check({name, "_accept_busy"}, 64'(busy), 64'd1);
        $display("req  %s op=%0d x=%h y=%h edge=%0d", name, o, a, b, acc_edge);
    endtask

    // lat counts cycles from the accept cycle to the first resp_valid cycle.
    task automatic do_req(input logic [1:0] o, input logic [NB-1:0] a, input logic [NB-1:0] b,
                          input logic [2*NB-1:0] exp_res, input int lat, input string name,
                          input bit wait_done);
        int   k;
        int   i;
        exp_t e;
        issue(o, a, b, name, k);
        if (k < 0) return;
        e.res = exp_res;
        e.due_edge = k + lat - 1;
        e.name = name;
        sb.push_back(e);
        if (wait_done) begin
            for (i = 0; i < 40; i++) begin
                @(posedge clk);
                #2;
                if (sb.size() == 0 && !resp_valid) break;
            end
            if (i == 40) check({name, "_done_timeout"}, 64'(sb.size()), 64'd0);
        end
    endtask

    task automatic quiet_window(input string name, input int n);
        int base;
        base = n_err;
        repeat (n) @(posedge clk);
        #1;
        check({name, "_no_stale_resp"}, 64'(n_err - base), 64'd0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        clear = 1'b0;
        req_valid = 1'b0;
        resp_ready = 1'b1;
        op = 2'd0;
        x = '0;
        y = '0;

        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release_ready", 64'(req_ready), 64'd1);

        do_req(2'd0, 15'h0005, 15'h7FFA, 30'h3FFFFFFF, 1,  "add_neg0", 1'b1);
        do_req(2'd1, 15'h0005, 15'h0003, 30'h00000002, 1,  "sub_eac", 1'b1);
        do_req(2'd1, 15'h0003, 15'h0005, 30'h3FFFFFFD, 1,  "sub_neg", 1'b1);
        do_req(2'd0, 15'h0003, 15'h0004, 30'h00000007, 1,  "add_pos", 1'b1);
        do_req(2'd0, 15'h7FFF, 15'h0000, 30'h3FFFFFFF, 1,  "add_m0", 1'b1);
        do_req(2'd3, 15'h1234, 15'h0055, 30'h00000000, 1,  "rsvd", 1'b1);
        do_req(2'd2, 15'h0003, 15'h0005, 30'h0000000F, 16, "mul_3x5", 1'b1);
        do_req(2'd2, 15'h7FFC, 15'h0005, 30'h3FFFFFF0, 16, "mul_n3x5", 1'b1);
        do_req(2'd2, 15'h3FFF, 15'h3FFF, 30'h0FFF8001, 16, "mul_max", 1'b1);
        do_req(2'd2, 15'h7FFF, 15'h1234, 30'h00000000, 16, "mul_m0", 1'b1);
        do_req(2'd2, 15'h7FFC, 15'h7FFA, 30'h0000000F, 16, "mul_nn", 1'b1);
        do_req(2'd2, 15'h0000, 15'h7FFF, 30'h00000000, 16, "mul_0xm0", 1'b1);
        do_req(2'd2, 15'h7FFE, 15'h3FFF, 30'h3FFFC000, 16, "mul_m1xmax", 1'b1);

        // Backpressure: DONE must hold its result while resp_ready is low.
        resp_ready = 1'b0;
        do_req(2'd0, 15'h0010, 15'h0020, 30'h00000030, 1, "hold_add", 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_resp_valid", 64'(resp_valid), 64'd1);
            check("hold_result", 64'(result), 64'h30);
            check("hold_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("handoff_resp_valid", 64'(resp_valid), 64'd0);
        check("handoff_busy", 64'(busy), 64'd0);
        check("handoff_req_ready", 64'(req_ready), 64'd1);
        k = cyc;
        do_req(2'd1, 15'h0009, 15'h0004, 30'h00000005, 1, "after_handoff", 1'b1);
        check("after_handoff_sb_empty", 64'(sb.size()), 64'd0);

        // Asynchronous reset in the middle of a multiply.
        issue(2'd2, 15'h0123, 15'h0045, "abort_rst", k);
        repeat (7) @(posedge clk);
        #1;
        check("abort_rst_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_rst_busy", 64'(busy), 64'd0);
        check("abort_rst_req_ready", 64'(req_ready), 64'd0);
        check("abort_rst_resp_valid", 64'(resp_valid), 64'd0);
        check("abort_rst_result", 64'(result), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_rst_release_ready", 64'(req_ready), 64'd1);
        quiet_window("abort_rst", 20);
        do_req(2'd2, 15'h0002, 15'h0003, 30'h00000006, 16, "post_rst_2x3", 1'b1);

        // Synchronous clear in the middle of a multiply.
        issue(2'd2, 15'h0123, 15'h0045, "abort_clr", k);
        repeat (7) @(posedge clk);
        #1;
        clear = 1'b1;
        #1;
        check("abort_clr_ready_masked", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        #1;
        check("abort_clr_busy", 64'(busy), 64'd0);
        check("abort_clr_resp_valid", 64'(resp_valid), 64'd0);
        check("abort_clr_req_ready", 64'(req_ready), 64'd1);
        quiet_window("abort_clr", 20);
        do_req(2'd2, 15'h0002, 15'h0003, 30'h00000006, 16, "post_clr_2x3", 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/agc_alu_seq.md
AGC_ALU_SEQ -- requirements
Module: agc_alu_seq

Interface
REQ-001 Parameter NUM_BIT, default 15: one's-complement word width, sign in the MSB.
REQ-002 clk  input  1  the single clock; every flop is clocked on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 clear  input  1  synchronous abort of any operation in flight.
REQ-005 req_valid  input  1  a request is presented on op/x/y.
REQ-006 req_ready  output  1  the block can accept a request.
REQ-007 op  input  2  operation: 0=ADD, 1=SUB, 2=MUL, 3=reserved.
REQ-008 x, y  input  NUM_BIT each  one's-complement operands.
REQ-009 resp_valid  output  1  result is valid.
REQ-010 resp_ready  input  1  the consumer accepts the result.
REQ-011 result  output  2*NUM_BIT  one's-complement result.
REQ-012 busy  output  1  high in any state except IDLE.

Function
REQ-013 The block SHALL be an FSM with states IDLE, MUL, FIX and DONE.
REQ-014 req_ready SHALL be high only in IDLE with clear low; a request is accepted on an edge where req_valid and req_ready are both high, and op, x and y are captured at that edge.
REQ-015 For ADD or SUB, the block SHALL go IDLE->DONE, with result = ones_comp_add_sub(x, y, op==SUB) sign-extended by replicating bit NUM_BIT-1 into the upper NUM_BIT bits.
REQ-016 ADD/SUB latency SHALL be 1 cycle: resp_valid is high in the cycle after acceptance.
REQ-017 For MUL, the block SHALL capture the sign as x[MSB]^y[MSB].
REQ-018 The MUL magnitudes SHALL be x[NUM_BIT-2:0] (inverted if x is negative) and likewise for y.
REQ-019 On a MUL accept, the block SHALL clear the NUM_BIT-bit accumulator, load the multiplier register with |y| and zero the iteration counter.
REQ-020 In MUL, each cycle SHALL compute acc = acc + (mq[0] ? |x| : 0) with a plain binary adder, then shift {acc,mq} right by one bit.
REQ-021 After exactly NUM_BIT-1 MUL cycles, at counter wrap, the block SHALL go to FIX.
REQ-022 In FIX, magnitude = {2'b00, acc[NUM_BIT-2:0], mq}, and result = sign ? ~magnitude : magnitude.
REQ-023 If the magnitude is zero, result SHALL be +0 (all zeros) regardless of sign.
REQ-024 FIX SHALL always go to DONE.
REQ-025 MUL latency SHALL be NUM_BIT+1 cycles from acceptance to the first resp_valid cycle (16 for NUM_BIT=15).
REQ-026 In DONE, resp_valid SHALL be high and result held stable until resp_valid and resp_ready are both high at an edge, which returns the FSM to IDLE.
REQ-027 A new request SHALL NOT be accepted in the same cycle as a result handoff; the minimum spacing is one IDLE cycle.
REQ-028 op=3 SHALL be accepted and complete like ADD with result zero.
REQ-029 clear high in any state SHALL force IDLE at the next edge and discard the pending result.
REQ-030 clear SHALL take priority over an accept or a handoff in the same cycle.
REQ-031 resp_ready low in DONE SHALL hold the state indefinitely, with no result change.
REQ-032 Outputs SHALL be registered; req_ready and busy are decoded from state only.

Reset
REQ-033 rst_n low SHALL immediately force state=IDLE, acc=0, mq=0, counter=0, sign=0, result=0 and resp_valid=0.
REQ-034 While rst_n is low, req_ready=0 and busy=0.
REQ-035 Reset asserted mid-MUL or in DONE SHALL abandon the operation; no stale result appears after release.
REQ-036 req_ready SHALL go high on the first rising clk edge after rst_n deasserts.

Structure
REQ-037 Package agc_alu_pkg SHALL hold the NUM_BIT default, alu_op_t (ADD/SUB/MUL/RSVD), alu_state_t, and MUL_ITER = NUM_BIT-1.
REQ-038 The block SHALL instantiate exactly one sub-module, ones_comp_add_sub, for the ADD/SUB path.
REQ-039 The MUL magnitude adder and counter SHALL be inline.

Verification
REQ-040 MUL x=15'h0003, y=15'h0005 -> result 30'h0000000F, resp_valid 16 cycles after accept.
REQ-041 MUL x=15'h7FFC (-3), y=15'h0005 -> result 30'h3FFFFFF0.
REQ-042 MUL x=y=15'h3FFF -> 30'h0FFF8001; MUL x=15'h7FFF (-0), y=15'h1234 -> 30'h00000000.
REQ-043 ADD x=15'h0005, y=15'h7FFA -> 30'h3FFFFFFF (-0); SUB x=15'h0005, y=15'h0003 -> 30'h00000002 via end-around carry; each resp_valid 1 cycle after accept.
REQ-044 Hold resp_ready=0 for 10 cycles in DONE -> result and resp_valid stable, req_ready=0; handoff -> IDLE, and the next request is accepted one cycle later.
REQ-045 Assert rst_n=0 (and separately clear=1) at MUL iteration 7 -> IDLE next, resp_valid never asserted; a subsequent 2*3 request -> 30'h00000006.
